// File: rtl/imm_operand_encoder.sv
// Sequential search for the {rotate_imm, immed_8} shifter operand of a 32-bit constant.
// One even rotation is tried per clock; the smallest rotate_imm that fits in 8 bits wins.
module imm_operand_encoder #(
    parameter int unsigned ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shifter_operand
);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    localparam logic [3:0] LAST_ROT = 4'(ROT_STEPS - 1);

    state_t      state_q,   state_d;
    logic [31:0] value_q,   value_d;
    logic [3:0]  rot_q,     rot_d;
    logic        done_q,    done_d;
    logic        valid_q,   valid_d;
    logic [11:0] operand_q, operand_d;

    logic [4:0]  shamt;
    logic [31:0] cand;

    // Undo immed_8 ROR (2*rot) by rotating the latched constant left; a
    // shift of 32 yields zero, so shamt==0 degenerates to the plain value.
    always_comb begin
        shamt = {rot_q, 1'b0};
        cand  = (value_q << shamt) | (value_q >> (6'd32 - {1'b0, shamt}));
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        rot_d     = rot_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        operand_d = operand_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = value;
                    rot_d   = '0;
                    state_d = SEARCH;
                end
            end

            SEARCH: begin
                if (cand[31:8] == '0) begin
                    operand_d = {rot_q, cand[7:0]};
                    valid_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (rot_q == LAST_ROT) begin
                    operand_d = '0;
                    valid_d   = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            value_q   <= '0;
            rot_q     <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            rot_q     <= rot_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            operand_q <= operand_d;
        end
    end

    assign busy            = (state_q == SEARCH);
    assign done            = done_q;
    assign valid           = valid_q;
    assign shifter_operand = operand_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Randomised bench for imm_operand_encoder against a brute-force search over
// every (immed_8, rotate_imm) pair.
module tb_imm_operand_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] shifter_operand;

    int n_checks = 0;
    int n_fail   = 0;

    logic        prev_valid = 1'b0;
    logic [11:0] prev_op    = '0;

    imm_operand_encoder #(.ROT_STEPS(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .value           (value),
        .busy            (busy),
        .done            (done),
        .valid           (valid),
        .shifter_operand (shifter_operand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror_bits(input logic [31:0] x, input int unsigned n);
        logic [31:0] r = x;
        for (int unsigned s = 0; s < n; s++) r = {r[0], r[31:1]};
        return r;
    endfunction

    // Exhaustive search in ARM terms: value == immed_8 ROR (2*rot), smallest rot first.
    task automatic model(input logic [31:0] v, output logic ok, output logic [11:0] op,
                         output int lat);
        ok  = 1'b0;
        op  = '0;
        lat = 16;
        for (int unsigned r = 0; r < 16 && !ok; r++) begin
            for (int unsigned i = 0; i < 256 && !ok; i++) begin
                if (ror_bits(32'(i), 2 * r) == v) begin
                    ok  = 1'b1;
                    op  = {4'(r), 8'(i)};
                    lat = int'(r) + 1;
                end
            end
        end
    endtask

    // Must be entered at #1 after an edge with the DUT able to accept.
    task automatic do_search(input logic [31:0] v, input int inj_at, input logic [31:0] inj_v,
                             input bit chain);
        logic        exp_ok;
        logic [11:0] exp_op;
        int          exp_lat;
        int          n;
        int          busy_cyc;

        model(v, exp_ok, exp_op, exp_lat);
        start = 1'b1;
        value = v;
        @(posedge clk); #1;
        start = 1'b0;
        value = $urandom;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        check("hold_valid", 32'(valid), 32'(prev_valid));
        check("hold_operand", 32'(shifter_operand), 32'(prev_op));

        n = 0;
        busy_cyc = 0;
        while (!done && n < 20) begin
            if (busy) busy_cyc++;
            if (n + 1 == inj_at) begin
                start = 1'b1;
                value = inj_v;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;

        check("latency", 32'(n), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cyc), 32'(exp_lat));
        check("done", 32'(done), 32'd1);
        check("valid", 32'(valid), 32'(exp_ok));
        check("operand", 32'(shifter_operand), 32'(exp_op));
        check("busy_after_done", 32'(busy), 32'd0);
        prev_valid = exp_ok;
        prev_op    = exp_op;

        if (!chain) begin
            @(posedge clk); #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    logic [31:0] directed [7] = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h000003FC,
                                  32'h00000000, 32'h00000101, 32'h00000102};

    initial begin
        logic [31:0] v;
        bit          saw_done;

        reset_n = 1'b1;
        start   = 1'b0;
        value   = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_operand", 32'(shifter_operand), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Spot checks on the model itself against hand-derived encodings.
        begin
            logic        ok;
            logic [11:0] op;
            int          lat;
            model(32'hFF000000, ok, op, lat);
            check("model_ff000000", {19'd0, ok, op}, {19'd0, 1'b1, 12'h4FF});
            model(32'h000003FC, ok, op, lat);
            check("model_3fc", {19'd0, ok, op}, {19'd0, 1'b1, 12'hFFF});
        end

        foreach (directed[i]) do_search(directed[i], 0, '0, 1'b0);

        // start during a search must be dropped
        do_search(32'h00000101, 4, 32'h000000FF, 1'b0);

        // back-to-back: second start lands in the done cycle
        do_search(32'hF000000F, 0, '0, 1'b1);
        do_search(32'h0003FC00, 0, '0, 1'b1);
        do_search(32'h00000102, 0, '0, 1'b0);

        for (int unsigned t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: v = ror_bits(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                1: v = ror_bits(32'($urandom_range(0, 255)), $urandom_range(0, 31));
                default: v = $urandom;
            endcase
            do_search(v, (t % 5 == 0) ? int'($urandom_range(1, 6)) : 0, $urandom, t[0]);
        end

        // Asynchronous reset between edges in the middle of a search.
        do_search(32'h000000FF, 0, '0, 1'b0);
        start = 1'b1;
        value = 32'h00000101;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_valid", 32'(valid), 32'd0);
        check("async_operand", 32'(shifter_operand), 32'd0);
        #2 reset_n = 1'b1;
        prev_valid = 1'b0;
        prev_op    = '0;
        saw_done   = 1'b0;
        for (int unsigned c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_reset", 32'(saw_done), 32'd0);
        do_search(32'h0000FF00, 0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
